// File: rtl/uart_tx_feeder_if.sv
// Bundle of the write-side FIFO port and the transmitter-core handshake for uart_tx_feeder.
// The slave modport is the feeder; the master modport is the producer plus transmitter core.
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;

    logic                   wr_en;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   full;
    logic                   empty;
    logic [LEVEL_WIDTH-1:0] level;
    logic                   overflow;
    logic                   tx_start;
    logic [DATA_WIDTH-1:0]  tx_data;
    logic                   tx_busy;
    logic                   timeout_err;

    modport master (
        output wr_en, wr_data, tx_busy,
        input  full, empty, level, overflow, tx_start, tx_data, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, tx_busy,
        output full, empty, level, overflow, tx_start, tx_data, timeout_err
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO that feeds a UART transmitter core one byte at a time, with a start strobe
// and a watchdog on the core's busy response.
module uart_tx_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_feeder_if.slave bus
);
    localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;
    localparam int CNT_WIDTH   = (BUSY_TIMEOUT < 1) ? 1 : $clog2(BUSY_TIMEOUT + 1);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL    = LEVEL_WIDTH'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0]   TIMEOUT_LIMIT = CNT_WIDTH'(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [LEVEL_WIDTH-1:0] level_q, level_next;
    logic                   full_q, empty_q, overflow_q;
    logic                   push, pop;

    logic                   tx_start_q, tx_start_next;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_next;
    logic                   timeout_q, timeout_next;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_next;

    // A write against a full FIFO is dropped even if a pop frees a slot at the same edge.
    assign push = bus.wr_en && !full_q;

    always_comb begin
        level_next = level_q;
        if (push && !pop) begin
            level_next = level_q + LEVEL_WIDTH'(1);
        end else if (pop && !push) begin
            level_next = level_q - LEVEL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            end
            level_q    <= level_next;
            full_q     <= (level_next == FULL_LEVEL);
            empty_q    <= (level_next == '0);
            overflow_q <= bus.wr_en && full_q;
        end
    end

    // Storage is left uncleared by reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state      <= state_next;
            tx_start_q <= tx_start_next;
            tx_data_q  <= tx_data_next;
            timeout_q  <= timeout_next;
            cnt_q      <= cnt_next;
        end
    end

    // The counter only advances below the limit, so it can never wrap.
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        tx_start_next = 1'b0;
        tx_data_next  = tx_data_q;
        timeout_next  = 1'b0;
        cnt_next      = cnt_q;
        case (state)
            IDLE: begin
                if (!empty_q) begin
                    pop          = 1'b1;
                    tx_data_next = mem[rd_ptr];
                    state_next   = START;
                end
            end
            START: begin
                tx_start_next = 1'b1;
                cnt_next      = '0;
                state_next    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_next = WAIT_DONE;
                end else if (cnt_q == TIMEOUT_LIMIT) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_q + CNT_WIDTH'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.full        = full_q;
    assign bus.empty       = empty_q;
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.timeout_err = timeout_q;
endmodule
